// File: rtl/ddr_cmd_sequencer_if.sv
// Request handshake and DRAM command bus between a requester and ddr_cmd_sequencer.
// master = requester side, slave = sequencer side.
interface ddr_cmd_sequencer_if #(
   parameter int unsigned width   = 8,
   parameter int unsigned rows    = 128,
   parameter int unsigned columns = 64
);
   localparam int unsigned RW = $clog2(rows);
   localparam int unsigned CW = $clog2(columns);

   logic             req_valid;
   logic             req_ready;
   logic             req_we;
   logic [RW-1:0]    req_row;
   logic [CW-1:0]    req_col;
   logic [width-1:0] req_data;

   logic             ACT;
   logic             RD;
   logic             WR;
   logic             PR;
   logic             REF;
   logic [RW-1:0]    row;
   logic [CW-1:0]    column;
   logic [width-1:0] dq;
   logic             wr_req;
   logic             rd_req;

   modport master (
      output req_valid, req_we, req_row, req_col, req_data,
      input  req_ready, ACT, RD, WR, PR, REF, row, column, dq, wr_req, rd_req
   );

   modport slave (
      input  req_valid, req_we, req_row, req_col, req_data,
      output req_ready, ACT, RD, WR, PR, REF, row, column, dq, wr_req, rd_req
   );
endinterface

// File: rtl/ddr_cmd_sequencer.sv
// Open-row request-to-command sequencer feeding the DRAM timing model.
// Optional auto refresh (tREFI/tRFC) is enabled by defining DDR_AUTO_REFRESH_EN.
module ddr_cmd_sequencer #(
   parameter int unsigned width   = 8,
   parameter int unsigned rows    = 128,
   parameter int unsigned columns = 64,
   parameter int unsigned TRCD    = 2,
   parameter int unsigned TRP     = 2,
   parameter int unsigned TRAS    = 5,
   parameter int unsigned TWR     = 2,
   parameter int unsigned TREFI   = 64,
   parameter int unsigned TRFC    = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               halt,
   ddr_cmd_sequencer_if.slave bus
);
   localparam int unsigned RW = $clog2(rows);
   localparam int unsigned CW = $clog2(columns);

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   localparam int unsigned T_MAX = max2(max2(max2(TRCD, TRP), max2(TRAS, TWR)), TRFC);
   localparam int unsigned CNT_W = (T_MAX > 0) ? $clog2(T_MAX + 1) : 1;

   typedef logic [CNT_W-1:0] cnt_t;

   // Counters hold T-1: a wait state exits when the count reaches <=1, so the
   // follow-on command lands exactly T cycles after the one that loaded it.
   function automatic cnt_t wait_load(input int unsigned t);
      return cnt_t'((t > 1) ? t - 1 : 0);
   endfunction

   typedef enum logic [2:0] {
      IDLE,
      ACTIVATING,
      OPEN,
      PRECHARGING,
      REFRESHING
   } state_t;

   state_t           state_q;
   cnt_t             wait_q;
   cnt_t             tras_q;
   cnt_t             twr_q;

   logic             held_q;
   logic             held_we_q;
   logic [RW-1:0]    held_row_q;
   logic [CW-1:0]    held_col_q;
   logic [width-1:0] held_data_q;
   logic [RW-1:0]    open_row_q;

   logic             act_q, rd_q, wr_q, pr_q, ref_q;
   logic [RW-1:0]    row_q;
   logic [CW-1:0]    column_q;
   logic [width-1:0] dq_q;

   logic             ref_pend;
   logic             ref_issue;
   logic             row_hit;
   logic             pr_ok;

   always_comb begin
      row_hit   = held_q && (held_row_q == open_row_q);
      pr_ok     = (tras_q == '0) && (twr_q == '0);
      ref_issue = !halt && (state_q == IDLE) && ref_pend;
   end

`ifdef DDR_AUTO_REFRESH_EN
   localparam int unsigned TMR_W = (TREFI > 1) ? $clog2(TREFI) : 1;

   logic [TMR_W-1:0] refi_q;
   logic             ref_pend_q;

   // A wrap on the same edge as a REF issue keeps the new request pending.
   always_ff @(posedge clk) begin
      if (rst) begin
         refi_q     <= '0;
         ref_pend_q <= 1'b0;
      end else if (!halt) begin
         if (refi_q == TMR_W'(TREFI - 1)) begin
            refi_q     <= '0;
            ref_pend_q <= 1'b1;
         end else begin
            refi_q <= refi_q + 1'b1;
            if (ref_issue) ref_pend_q <= 1'b0;
         end
      end
   end

   assign ref_pend = ref_pend_q;
`else
   assign ref_pend = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         wait_q      <= '0;
         tras_q      <= '0;
         twr_q       <= '0;
         held_q      <= 1'b0;
         held_we_q   <= 1'b0;
         held_row_q  <= '0;
         held_col_q  <= '0;
         held_data_q <= '0;
         open_row_q  <= '0;
         act_q       <= 1'b0;
         rd_q        <= 1'b0;
         wr_q        <= 1'b0;
         pr_q        <= 1'b0;
         ref_q       <= 1'b0;
         row_q       <= '0;
         column_q    <= '0;
         dq_q        <= '0;
      end else if (halt) begin
         act_q <= 1'b0;
         rd_q  <= 1'b0;
         wr_q  <= 1'b0;
         pr_q  <= 1'b0;
         ref_q <= 1'b0;
      end else begin
         act_q <= 1'b0;
         rd_q  <= 1'b0;
         wr_q  <= 1'b0;
         pr_q  <= 1'b0;
         ref_q <= 1'b0;

         if (bus.req_valid && !held_q) begin
            held_q      <= 1'b1;
            held_we_q   <= bus.req_we;
            held_row_q  <= bus.req_row;
            held_col_q  <= bus.req_col;
            held_data_q <= bus.req_data;
         end

         if (tras_q != '0) tras_q <= tras_q - 1'b1;
         if (twr_q != '0)  twr_q  <= twr_q - 1'b1;

         case (state_q)
            IDLE: begin
               if (ref_pend) begin
                  ref_q   <= 1'b1;
                  wait_q  <= wait_load(TRFC);
                  state_q <= (TRFC > 1) ? REFRESHING : IDLE;
               end else if (held_q) begin
                  act_q      <= 1'b1;
                  row_q      <= held_row_q;
                  open_row_q <= held_row_q;
                  tras_q     <= wait_load(TRAS);
                  wait_q     <= wait_load(TRCD);
                  state_q    <= (TRCD > 1) ? ACTIVATING : OPEN;
               end
            end
            ACTIVATING: begin
               if (wait_q <= cnt_t'(1)) state_q <= OPEN;
               else                     wait_q  <= wait_q - 1'b1;
            end
            OPEN: begin
               if (ref_pend || (held_q && !row_hit)) begin
                  if (pr_ok) begin
                     pr_q    <= 1'b1;
                     wait_q  <= wait_load(TRP);
                     state_q <= (TRP > 1) ? PRECHARGING : IDLE;
                  end
               end else if (held_q) begin
                  column_q <= held_col_q;
                  held_q   <= 1'b0;
                  if (held_we_q) begin
                     wr_q  <= 1'b1;
                     dq_q  <= held_data_q;
                     twr_q <= wait_load(TWR);
                  end else begin
                     rd_q <= 1'b1;
                  end
               end
            end
            PRECHARGING, REFRESHING: begin
               if (wait_q <= cnt_t'(1)) state_q <= IDLE;
               else                     wait_q  <= wait_q - 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready = !held_q && !halt;
   assign bus.ACT       = act_q;
   assign bus.RD        = rd_q;
   assign bus.WR        = wr_q;
   assign bus.PR        = pr_q;
   assign bus.REF       = ref_q;
   assign bus.row       = row_q;
   assign bus.column    = column_q;
   assign bus.dq        = dq_q;
   assign bus.wr_req    = wr_q;
   assign bus.rd_req    = rd_q;
endmodule

// File: tb/tb_ddr_cmd_sequencer.sv
// Directed bench for ddr_cmd_sequencer: closed-row, row-hit, row-miss, halt and reset timing.
// The refresh scenario is compiled only when DDR_AUTO_REFRESH_EN is defined.
module tb_ddr_cmd_sequencer;
   localparam logic [4:0] C0 = 5'b00000;
   localparam logic [4:0] CA = 5'b10000;
   localparam logic [4:0] CR = 5'b01000;
   localparam logic [4:0] CW = 5'b00100;
   localparam logic [4:0] CP = 5'b00010;
   localparam logic [4:0] CF = 5'b00001;

   logic clk;
   logic rst;
   logic halt;
   int   n_total;
   int   n_pass;

   ddr_cmd_sequencer_if #(.width(8), .rows(128), .columns(64)) bus ();

   ddr_cmd_sequencer #(
      .width(8), .rows(128), .columns(64),
      .TRCD(2), .TRP(2), .TRAS(5), .TWR(2), .TREFI(64), .TRFC(4)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .halt (halt),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [4:0] cmd();
      return {bus.ACT, bus.RD, bus.WR, bus.PR, bus.REF};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic we, input logic [6:0] r, input logic [5:0] c,
                            input logic [7:0] d);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_row   = r;
      bus.req_col   = c;
      bus.req_data  = d;
   endtask

   task automatic idle_req();
      bus.req_valid = 1'b0;
   endtask

   // Leaves the bench in the cycle just after the last reset edge; the next edge is edge 0.
   task automatic do_reset();
      rst  = 1'b1;
      halt = 1'b0;
      idle_req();
      step();
      step();
      rst = 1'b0;
   endtask

   logic [4:0] exp_seq  [0:13] = '{C0, CA, C0, CW, C0, C0, CR, C0, CP, C0, CA, C0, CR, C0};
   logic [4:0] exp_halt [0:11] = '{C0, CA, C0, C0, C0, C0, CW, C0, C0, C0, CR, C0};
   logic [4:0] exp_rst  [0:6]  = '{C0, CA, C0, C0, C0, C0, C0};

   initial begin
      n_total = 0;
      n_pass  = 0;
      bus.req_we   = 1'b0;
      bus.req_row  = '0;
      bus.req_col  = '0;
      bus.req_data = '0;

      // Closed-row write, row-hit read, row-miss read
      do_reset();
      check("rst_cmd", 32'(cmd()), 32'(C0));
      check("rst_row", 32'(bus.row), 0);
      check("rst_col", 32'(bus.column), 0);
      check("rst_dq", 32'(bus.dq), 0);
      check("rst_rdwr_req", 32'({bus.wr_req, bus.rd_req}), 0);
      check("rst_ready", 32'(bus.req_ready), 1);
      drive_req(1'b1, 7'd3, 6'd5, 8'hA5);
      for (int c = 0; c <= 13; c++) begin
         step();
         check($sformatf("seq_cmd_c%0d", c), 32'(cmd()), 32'(exp_seq[c]));
         case (c)
            0: idle_req();
            1: check("seq_act_row", 32'(bus.row), 3);
            3: begin
               check("seq_wr_col", 32'(bus.column), 5);
               check("seq_wr_dq", 32'(bus.dq), 'hA5);
               check("seq_wr_req", 32'({bus.wr_req, bus.rd_req}), 2);
            end
            4: begin
               check("seq_slot_free", 32'(bus.req_ready), 1);
               drive_req(1'b0, 7'd3, 6'd6, 8'h00);
            end
            5: idle_req();
            6: begin
               check("seq_rd_col", 32'(bus.column), 6);
               check("seq_rd_req", 32'({bus.wr_req, bus.rd_req}), 1);
               drive_req(1'b0, 7'd7, 6'd1, 8'h00);
            end
            7: idle_req();
            8: begin
               check("seq_col_hold", 32'(bus.column), 6);
               check("seq_dq_hold", 32'(bus.dq), 'hA5);
            end
            10: check("seq_miss_act_row", 32'(bus.row), 7);
            12: check("seq_miss_rd_col", 32'(bus.column), 1);
            default: ;
         endcase
      end

      // Halt during ACTIVATING, then halt blocking acceptance
      do_reset();
      drive_req(1'b1, 7'd3, 6'd5, 8'hA5);
      for (int c = 0; c <= 11; c++) begin
         step();
         check($sformatf("halt_cmd_c%0d", c), 32'(cmd()), 32'(exp_halt[c]));
         case (c)
            0: idle_req();
            1: halt = 1'b1;
            4: halt = 1'b0;
            6: begin
               check("halt_wr_col", 32'(bus.column), 5);
               check("halt_wr_dq", 32'(bus.dq), 'hA5);
            end
            7: begin
               halt = 1'b1;
               drive_req(1'b0, 7'd3, 6'd2, 8'h00);
               #1;
               check("halt_ready_low", 32'(bus.req_ready), 0);
            end
            8: halt = 1'b0;
            9: idle_req();
            10: check("halt_rd_col", 32'(bus.column), 2);
            default: ;
         endcase
      end

      // Reset during ACTIVATING aborts the write
      do_reset();
      drive_req(1'b1, 7'd3, 6'd5, 8'hA5);
      for (int c = 0; c <= 6; c++) begin
         step();
         check($sformatf("mrst_cmd_c%0d", c), 32'(cmd()), 32'(exp_rst[c]));
         case (c)
            0: idle_req();
            2: rst = 1'b1;
            3: begin
               check("mrst_row", 32'(bus.row), 0);
               check("mrst_col_dq", 32'({bus.column, bus.dq}), 0);
               check("mrst_rdwr_req", 32'({bus.wr_req, bus.rd_req}), 0);
               rst = 1'b0;
            end
            4: check("mrst_ready", 32'(bus.req_ready), 1);
            default: ;
         endcase
      end

`ifdef DDR_AUTO_REFRESH_EN
      // Refresh with row 3 left open and idle
      do_reset();
      drive_req(1'b1, 7'd3, 6'd5, 8'hA5);
      for (int c = 0; c <= 71; c++) begin
         logic [4:0] e;
         step();
         case (c)
            1, 70: e = CA;
            3:     e = CW;
            64:    e = CP;
            66:    e = CF;
            default: e = C0;
         endcase
         check($sformatf("ref_cmd_c%0d", c), 32'(cmd()), 32'(e));
         if (c == 0) idle_req();
         if (c == 65) drive_req(1'b0, 7'd9, 6'd4, 8'h00);
         if (c == 66) idle_req();
         if (c == 70) check("ref_act_row", 32'(bus.row), 9);
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
